// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: request/data in, grant and
// stored-value status out.
interface dff_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [IDW-1:0]        q_owner;
  logic                  q_valid;
  logic                  busy;

  modport master (
    output req, din,
    input  gnt, q, q_owner, q_valid, busy
  );

  modport slave (
    input  req, din,
    output gnt, q, q_owner, q_valid, busy
  );
endinterface

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register; the winner's data is
// captured on the grant edge, followed by one mandatory GAP cycle.
module dff_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  dff_share_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GAP} state_e;

  state_e           state_q;
  logic [IDW-1:0]   last_q;
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] q_q;
  logic [IDW-1:0]   owner_q;
  logic             valid_q;

  logic             win_found_d;
  logic [IDW-1:0]   win_idx_d;
  int unsigned      cand;

  // Scan last+1, last+2, ... modulo NREQ; the first requester found wins.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_q) + k) % NREQ;
      if (!win_found_d && bus.req[cand]) begin
        win_found_d = 1'b1;
        win_idx_d   = IDW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      gnt_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            q_q     <= bus.din[win_idx_d*WIDTH +: WIDTH];
            owner_q <= win_idx_d;
            valid_q <= 1'b1;
            last_q  <= win_idx_d;
            gnt_q   <= NREQ'(1) << win_idx_d;
            state_q <= GAP;
          end else begin
            gnt_q   <= '0;
          end
        end
        GAP: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = q_q;
  assign bus.q_owner = owner_q;
  assign bus.q_valid = valid_q;
  assign bus.busy    = (state_q == GAP);

endmodule
